// File: rtl/rv32_muldiv_iter_if.sv
// Request/response bundle for the iterative RV32/RV64 M-extension unit.
//   master: drives the request (valid/op/operands/tag), flush and resp_ready
//   slave : the unit; returns req_ready, resp_valid/data/tag and busy
interface rv32_muldiv_iter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_op_i;
  logic [XLEN-1:0]  req_a_i;
  logic [XLEN-1:0]  req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             flush_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [XLEN-1:0]  resp_data_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic             busy_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, flush_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_tag_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, flush_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_tag_o, busy_o
  );
endinterface

// File: rtl/rv32_muldiv_iter.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, retiring
// BITS_PER_CYCLE bits per CALC cycle, with sign fixup on the final edge.
// Divide-by-zero and signed overflow complete on the edge after accept.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : request/response handshake (slave modport), see rv32_muldiv_iter_if
module rv32_muldiv_iter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_W          = 5
) (
  input logic               clk_i,
  input logic               rst_n_i,
  rv32_muldiv_iter_if.slave bus
);
  localparam int unsigned ITER  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  acc;        // product high half / partial remainder
  logic [XLEN-1:0]  lo;         // multiplier->product low half / dividend->quotient
  logic [XLEN-1:0]  mag_b;      // multiplicand / divisor magnitude
  logic             neg_q;      // product or quotient negative
  logic             rem_neg_q;  // remainder negative (sign of dividend)
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  logic            ready, accept;
  logic [2:0]      op_in;
  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a_in, mag_b_in, special;

  assign ready  = !bus.flush_i && (state == IDLE || (state == DONE && bus.resp_ready_i));
  assign accept = bus.req_valid_i && ready;

  assign bus.req_ready_o  = ready;
  assign bus.resp_valid_o = (state == DONE);
  assign bus.busy_o       = (state != IDLE);
  assign bus.resp_data_o  = resp_data;
  assign bus.resp_tag_o   = resp_tag;

  always_comb begin
    op_in    = bus.req_op_i;
    a_signed = (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd4) || (op_in == 3'd6);
    b_signed = (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
    a_neg    = a_signed && bus.req_a_i[XLEN-1];
    b_neg    = b_signed && bus.req_b_i[XLEN-1];
    mag_a_in = a_neg ? -bus.req_a_i : bus.req_a_i;
    mag_b_in = b_neg ? -bus.req_b_i : bus.req_b_i;
    div_zero = op_in[2] && (bus.req_b_i == '0);
    div_ovf  = op_in[2] && !op_in[0] &&
               (bus.req_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b_i == '1);
    if (div_zero) special = op_in[1] ? bus.req_a_i : '1;
    else          special = op_in[1] ? '0 : bus.req_a_i;
  end

  logic [XLEN-1:0]   nxt_acc, nxt_lo, quo, rem, result;
  logic [XLEN:0]     trial, sum;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    nxt_acc = acc;
    nxt_lo  = lo;
    trial   = '0;
    sum     = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        // Restoring step: shift next dividend bit into the remainder.
        trial  = {nxt_acc, nxt_lo[XLEN-1]};
        nxt_lo = {nxt_lo[XLEN-2:0], 1'b0};
        if (trial >= {1'b0, mag_b}) begin
          trial     = trial - {1'b0, mag_b};
          nxt_lo[0] = 1'b1;
        end
        nxt_acc = trial[XLEN-1:0];
      end else begin
        // Shift-add step: {acc, lo} shifts right, carry enters acc MSB.
        sum     = {1'b0, nxt_acc} + (nxt_lo[0] ? {1'b0, mag_b} : '0);
        nxt_lo  = {sum[0], nxt_lo[XLEN-1:1]};
        nxt_acc = sum[XLEN:1];
      end
    end
    prod = {nxt_acc, nxt_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -nxt_lo : nxt_lo;
    rem = rem_neg_q ? -nxt_acc : nxt_acc;
    case (op_q)
      3'd0:                result = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    result = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          result = quo;
      default:             result = rem;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      acc       <= '0;
      lo        <= '0;
      mag_b     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      resp_data <= '0;
      resp_tag  <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (accept) begin
      op_q      <= op_in;
      tag_q     <= bus.req_tag_i;
      acc       <= '0;
      lo        <= mag_a_in;
      mag_b     <= mag_b_in;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      if (div_zero || div_ovf) begin
        state     <= DONE;
        cnt       <= '0;
        resp_data <= special;
        resp_tag  <= bus.req_tag_i;
      end else begin
        state <= CALC;
        cnt   <= CNT_W'(ITER);
      end
    end else begin
      case (state)
        CALC: begin
          acc <= nxt_acc;
          lo  <= nxt_lo;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            resp_data <= result;
            resp_tag  <= tag_q;
          end
        end
        DONE:    if (bus.resp_ready_i) state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_muldiv_iter.sv
// Scoreboard bench for rv32_muldiv_iter: three instances
//   0: XLEN=32 BITS_PER_CYCLE=1, 1: XLEN=32 BITS_PER_CYCLE=4, 2: XLEN=64 BITS_PER_CYCLE=2
// Drivers push expected responses; one monitor compares whenever resp_valid_o is high.
module tb_rv32_muldiv_iter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid[3];
  logic [2:0]  req_op[3];
  logic [63:0] req_a[3], req_b[3];
  logic [4:0]  req_tag[3];
  logic        flush[3], resp_ready[3];
  logic        ready[3], rv[3], busy[3];
  logic [63:0] rd[3];
  logic [4:0]  rt[3];

  rv32_muldiv_iter_if #(.XLEN(32), .TAG_W(5)) if0 ();
  rv32_muldiv_iter_if #(.XLEN(32), .TAG_W(5)) if1 ();
  rv32_muldiv_iter_if #(.XLEN(64), .TAG_W(5)) if2 ();

  rv32_muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(if0.slave));
  rv32_muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(if1.slave));
  rv32_muldiv_iter #(.XLEN(64), .BITS_PER_CYCLE(2), .TAG_W(5)) dut2 (.clk_i(clk), .rst_n_i(rst_n), .bus(if2.slave));

  assign if0.req_valid_i = req_valid[0];  assign if0.req_op_i = req_op[0];
  assign if0.req_a_i = req_a[0][31:0];    assign if0.req_b_i = req_b[0][31:0];
  assign if0.req_tag_i = req_tag[0];      assign if0.flush_i = flush[0];
  assign if0.resp_ready_i = resp_ready[0];
  assign ready[0] = if0.req_ready_o;      assign rv[0] = if0.resp_valid_o;
  assign busy[0] = if0.busy_o;            assign rd[0] = {32'b0, if0.resp_data_o};
  assign rt[0] = if0.resp_tag_o;

  assign if1.req_valid_i = req_valid[1];  assign if1.req_op_i = req_op[1];
  assign if1.req_a_i = req_a[1][31:0];    assign if1.req_b_i = req_b[1][31:0];
  assign if1.req_tag_i = req_tag[1];      assign if1.flush_i = flush[1];
  assign if1.resp_ready_i = resp_ready[1];
  assign ready[1] = if1.req_ready_o;      assign rv[1] = if1.resp_valid_o;
  assign busy[1] = if1.busy_o;            assign rd[1] = {32'b0, if1.resp_data_o};
  assign rt[1] = if1.resp_tag_o;

  assign if2.req_valid_i = req_valid[2];  assign if2.req_op_i = req_op[2];
  assign if2.req_a_i = req_a[2];          assign if2.req_b_i = req_b[2];
  assign if2.req_tag_i = req_tag[2];      assign if2.flush_i = flush[2];
  assign if2.resp_ready_i = resp_ready[2];
  assign ready[2] = if2.req_ready_o;      assign rv[2] = if2.resp_valid_o;
  assign busy[2] = if2.busy_o;            assign rd[2] = if2.resp_data_o;
  assign rt[2] = if2.resp_tag_o;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[3][$];
  bit          seen[3];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          rr_force;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned xl_of(input int k);
    return (k == 2) ? 64 : 32;
  endfunction

  function automatic int unsigned iter_of(input int k);
    return (k == 1) ? 8 : 32;
  endfunction

  function automatic logic [63:0] mask_of(input int k);
    return (k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Reference: exact wide signed arithmetic, truncated to XLEN.
  function automatic logic [63:0] model(input int unsigned xl, input logic [2:0] op,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, sbv, ua, ub, r;
    if (xl == 32) begin
      sa  = {{98{a[31]}}, a[31:0]};  sbv = {{98{b[31]}}, b[31:0]};
      ua  = {98'b0, a[31:0]};        ub  = {98'b0, b[31:0]};
    end else begin
      sa  = {{66{a[63]}}, a};        sbv = {{66{b[63]}}, b};
      ua  = {66'b0, a};              ub  = {66'b0, b};
    end
    case (op)
      3'd0:    r = sa * sbv;
      3'd1:    r = (sa * sbv) >>> xl;
      3'd2:    r = (sa * ub) >>> xl;
      3'd3:    r = (ua * ub) >>> xl;
      3'd4:    r = (ub == 0) ? -1 : sa / sbv;
      3'd5:    r = (ub == 0) ? -1 : ua / ub;
      3'd6:    r = (ub == 0) ? sa : sa % sbv;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return (xl == 32) ? {32'b0, r[31:0]} : r[63:0];
  endfunction

  function automatic int unsigned lat_of(input int k, input logic [2:0] op,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, mn;
    m  = mask_of(k);
    mn = (k == 2) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (op[2] && (b & m) == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && (a & m) == mn && (b & m) == m) return 1;
    return iter_of(k) + 1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%h exp=%h", nm, k, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp);
    exp_t e;
    e.data = exp;
    e.tag  = tag;
    e.acc  = cyc;
    e.lat  = lat_of(k, op, a, b);
    sb[k].push_back(e);
  endtask

  task automatic scramble(input int k);
    req_valid[k] = 1'b0;
    req_op[k]    = 3'($urandom);
    req_a[k]     = {$urandom, $urandom};
    req_b[k]     = {$urandom, $urandom};
  endtask

  task automatic issue(input int k, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp);
    int n = 0;
    @(negedge clk);
    req_valid[k] = 1'b1; req_op[k] = op; req_a[k] = a; req_b[k] = b; req_tag[k] = tag;
    #1;
    while (!ready[k] && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (!ready[k]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d got=ready0 exp=ready1", k);
    end else push_exp(k, op, a, b, tag, exp);
    @(posedge clk); #1;
    scramble(k);
  endtask

  task automatic rand_issue(input int k);
    logic [2:0]  op;
    logic [63:0] a, b, m;
    int unsigned sel;
    m   = mask_of(k);
    op  = (k == 2 && $urandom_range(0, 1) == 1) ? 3'd3 : 3'($urandom_range(0, 7));
    a   = {$urandom, $urandom} & m;
    b   = {$urandom, $urandom} & m;
    sel = $urandom_range(0, 7);
    if (sel == 0) b = '0;
    if (sel == 1) begin
      a = (k == 2) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      b = m;
    end
    if (sel == 2) b = 64'($urandom_range(1, 15));
    issue(k, op, a, b, 5'($urandom), model(xl_of(k), op, a, b));
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (sb[k].size() != 0 && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("drain", k, 64'(sb[k].size()), 64'd0);
  endtask

  // Monitor: every cycle a response is presented it must match the queue head,
  // which also proves it holds steady under back-pressure.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (rv[k]) begin
          if (sb[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_resp dut%0d got=%h exp=none", k, rd[k]);
          end else begin
            e = sb[k][0];
            if (!seen[k]) begin
              seen[k] = 1'b1;
              chk("latency", k, 64'(cyc - e.acc), 64'(e.lat));
            end
            chk("resp_data", k, rd[k], e.data);
            chk("resp_tag", k, 64'(rt[k]), 64'(e.tag));
            if (resp_ready[k]) begin
              void'(sb[k].pop_front());
              seen[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk)
    if (!rr_force)
      for (int k = 0; k < 3; k++) resp_ready[k] = ($urandom_range(0, 3) != 0);

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a, b, exp;
  } vec_t;
  vec_t dv[12];

  initial begin
    int n;
    dv[0]  = '{3'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB};
    dv[1]  = '{3'd1, 64'h80000000, 64'h80000000, 64'h40000000};
    dv[2]  = '{3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE};
    dv[3]  = '{3'd2, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF};
    dv[4]  = '{3'd4, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD};
    dv[5]  = '{3'd6, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF};
    dv[6]  = '{3'd5, 64'd100,      64'd7,        64'd14};
    dv[7]  = '{3'd7, 64'd100,      64'd7,        64'd2};
    dv[8]  = '{3'd5, 64'h1234,     64'h0,        64'hFFFFFFFF};
    dv[9]  = '{3'd7, 64'h1234,     64'h0,        64'h1234};
    dv[10] = '{3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000};
    dv[11] = '{3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h0};

    rr_force = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_op[k] = '0; req_a[k] = '0; req_b[k] = '0;
      req_tag[k] = '0; flush[k] = 1'b0; resp_ready[k] = 1'b1; seen[k] = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", k, 64'(ready[k]), 64'd1);
      chk("rst_valid", k, 64'(rv[k]), 64'd0);
      chk("rst_busy", k, 64'(busy[k]), 64'd0);
      chk("rst_data", k, rd[k], 64'd0);
      chk("rst_tag", k, 64'(rt[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors on both 32-bit configurations (latency 33 and 9).
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 12; i++)
        issue(k, dv[i].op, dv[i].a, dv[i].b, (i == 0) ? 5'd5 : 5'(i + 8), dv[i].exp);
      drain(k);
    end

    // Random sweep with random back-pressure.
    rr_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (40) rand_issue(k);
      drain(k);
    end
    rr_force = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) resp_ready[k] = 1'b1;

    // Flush in CALC cycle 10.
    issue(0, 3'd0, 64'd12345, 64'd678, 5'd1, 64'd8369910);
    repeat (10) @(negedge clk);
    flush[0] = 1'b1;
    #1;
    chk("flush_ready", 0, 64'(ready[0]), 64'd0);
    void'(sb[0].pop_back());
    seen[0] = 1'b0;
    @(negedge clk);
    flush[0] = 1'b0;
    #1;
    chk("flush_busy", 0, 64'(busy[0]), 64'd0);
    chk("flush_valid", 0, 64'(rv[0]), 64'd0);
    issue(0, 3'd5, 64'd100, 64'd7, 5'd2, 64'd14);
    drain(0);

    // Hold result under back-pressure, then release with a queued request.
    @(negedge clk);
    resp_ready[0] = 1'b0;
    issue(0, 3'd0, 64'h7, 64'hFFFFFFFD, 5'd5, 64'hFFFFFFEB);
    n = 0;
    while (!rv[0] && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("bp_valid", 0, 64'(rv[0]), 64'd1);
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_hold_data", 0, rd[0], 64'hFFFFFFEB);
      chk("bp_hold_tag", 0, 64'(rt[0]), 64'd5);
    end
    @(negedge clk);
    resp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_op[0] = 3'd7; req_a[0] = 64'd100; req_b[0] = 64'd7; req_tag[0] = 5'd9;
    #1;
    chk("b2b_ready", 0, 64'(ready[0]), 64'd1);
    push_exp(0, 3'd7, 64'd100, 64'd7, 5'd9, 64'd2);
    @(posedge clk); #1;
    scramble(0);
    drain(0);

    // Asynchronous reset mid-CALC.
    issue(0, 3'd1, 64'h12345678, 64'h9ABCDEF0, 5'd3, 64'h0);
    repeat (5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 0, 64'(rv[0]), 64'd0);
    chk("midrst_busy", 0, 64'(busy[0]), 64'd0);
    chk("midrst_ready", 0, 64'(ready[0]), 64'd1);
    chk("midrst_data", 0, rd[0], 64'd0);
    chk("midrst_tag", 0, 64'(rt[0]), 64'd0);
    sb[0].delete();
    seen[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 3'd6, 64'hFFFFFFF9, 64'h2, 5'd4, 64'hFFFFFFFF);
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32_muldiv_iter.md
RV32_MULDIV_ITER -- requirements
Module: rv32_muldiv_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width; legal values 32 or 64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: bits retired per iteration; legal values 1, 2, 4; must divide XLEN.
REQ-003 SHALL have parameter TAG_W, default 5: destination-register tag width.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid_i, input, 1: request valid.
REQ-007 SHALL have port req_ready_o, output, 1: unit can accept a request.
REQ-008 SHALL have port req_op_i, input, 3: RISC-V M funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-009 SHALL have ports req_a_i and req_b_i, input, XLEN each: rs1 and rs2 operands.
REQ-010 SHALL have port req_tag_i, input, TAG_W: rd tag, returned unchanged on resp_tag_o.
REQ-011 SHALL have port flush_i, input, 1: kill the in-flight operation.
REQ-012 SHALL have port resp_valid_o, output, 1: result valid.
REQ-013 SHALL have port resp_ready_i, input, 1: consumer accepts the result.
REQ-014 SHALL have port resp_data_o, output, XLEN: result.
REQ-015 SHALL have port resp_tag_o, output, TAG_W: tag of the result.
REQ-016 SHALL have port busy_o, output, 1: high in any state other than IDLE; drives the hazard unit's stall.

Function
REQ-017 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-018 Accept SHALL occur when req_valid_i and req_ready_o are both high; req_ready_o = IDLE, or (DONE and resp_ready_i), so back-to-back operation runs with no bubble.
REQ-019 On accept, the unit SHALL latch op, tag and operand magnitudes plus result-sign flags; signedness per op (MULHSU: a signed, b unsigned).
REQ-020 A normal accept SHALL go to CALC with iteration counter ITER = XLEN/BITS_PER_CYCLE.
REQ-021 Each CALC edge SHALL retire BITS_PER_CYCLE bits (shift-add multiply or restoring divide) and decrement the counter; the edge that reaches zero SHALL apply sign fixup and go to DONE.
REQ-022 Latency SHALL be: resp_valid_o high exactly ITER+1 cycles after the accept cycle (33 for the defaults).
REQ-023 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-024 Divide by zero SHALL skip CALC and reach DONE on the edge after accept: DIV/DIVU quotient all-ones; REM/REMU return the dividend.
REQ-025 Signed overflow (DIV/REM of -2^(XLEN-1) by -1) SHALL skip CALC and reach DONE on the edge after accept: quotient = dividend, remainder = 0.
REQ-026 Signed remainder SHALL take the sign of the dividend; signed quotient SHALL truncate toward zero.
REQ-027 In DONE, resp_valid_o, resp_data_o and resp_tag_o SHALL hold stable until resp_ready_i is high.
REQ-028 From DONE, resp_ready_i without a new accept SHALL go to IDLE; resp_ready_i with a new accept SHALL go to CALC (or DONE for the REQ-024/REQ-025 cases).
REQ-029 flush_i SHALL force IDLE on the next edge from any state, discarding the result; flush_i takes priority over a same-cycle accept, so req_ready_o is low while flush_i is high.
REQ-030 req_a_i, req_b_i and req_op_i changing after accept SHALL NOT affect the result.

Reset
REQ-031 Asserting rst_n_i low SHALL immediately force IDLE, resp_valid_o = 0, busy_o = 0, resp_data_o = 0, resp_tag_o = 0, counter = 0 and req_ready_o = 1.
REQ-032 Reset mid-CALC or in DONE SHALL abort without producing a response; the first accept after deassertion SHALL behave normally.

Verification
REQ-033 MUL a=7, b=0xFFFFFFFD, tag 5 -> resp_data_o=0xFFFFFFEB, resp_tag_o=5, resp_valid_o 33 cycles after accept.
REQ-034 MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-036 DIVU 0x1234/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234, each 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each 1 cycle after accept.
REQ-037 flush_i pulsed in CALC cycle 10 -> IDLE next cycle, no resp_valid_o; the next request completes correctly.
REQ-038 resp_ready_i held low 5 cycles in DONE -> data stable; then resp_ready_i high with a queued request -> new op accepted the same cycle.
REQ-039 Repeat with BITS_PER_CYCLE=4 -> latency 9 and identical results; XLEN=64 MULHU random sweep checked against a model.
